// File: rtl/bsg_gray_to_binary.sv
// Gray-to-binary conversion: each binary bit is the XOR of all gray bits at or above it.
module bsg_gray_to_binary #(
  parameter int width_p = 7
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  for (genvar i = 0; i < width_p; i++) begin : g_bit
    assign binary_o[i] = ^gray_i[width_p-1:i];
  end

endmodule

// File: rtl/bsg_async_ptr_gray_reader.sv
// Read-side pointer controller of a gray-coded async FIFO: owns the read pointer,
// derives valid/empty and occupancy, and flags dequeues attempted while empty.
module bsg_async_ptr_gray_reader #(
  parameter int lg_size_p = 7
) (
  input  logic                 r_clk_i,
  input  logic                 r_reset_i,
  input  logic [lg_size_p-1:0] w_ptr_gray_rsync_i,
  input  logic                 r_yumi_i,
  output logic                 r_valid_o,
  output logic                 r_empty_o,
  output logic [lg_size_p-1:0] r_ptr_binary_r_o,
  output logic [lg_size_p-1:0] r_ptr_gray_r_o,
  output logic [lg_size_p-1:0] r_count_r_o,
  output logic                 r_underflow_r_o
);

  localparam logic [lg_size_p-1:0] one_lp = lg_size_p'(1);

  logic [lg_size_p-1:0] r_ptr_p1_r;
  logic [lg_size_p-1:0] w_ptr_binary;
  logic [lg_size_p-1:0] r_ptr_binary_next;
  logic                 r_deq;

  bsg_gray_to_binary #(.width_p(lg_size_p)) w_g2b (
    .gray_i   (w_ptr_gray_rsync_i),
    .binary_o (w_ptr_binary)
  );

  // Equal gray pointers mean empty; no binary conversion is needed for that test.
  assign r_valid_o = (w_ptr_gray_rsync_i != r_ptr_gray_r_o);
  assign r_empty_o = ~r_valid_o;
  assign r_deq     = r_yumi_i & r_valid_o;

  assign r_ptr_binary_next = r_deq ? r_ptr_p1_r : r_ptr_binary_r_o;

  always_ff @(posedge r_clk_i or posedge r_reset_i) begin
    if (r_reset_i) begin
      r_ptr_binary_r_o <= '0;
      r_ptr_gray_r_o   <= '0;
      r_ptr_p1_r       <= one_lp;
      r_count_r_o      <= '0;
      r_underflow_r_o  <= 1'b0;
    end else begin
      if (r_deq) begin
        r_ptr_binary_r_o <= r_ptr_p1_r;
        r_ptr_p1_r       <= r_ptr_p1_r + one_lp;
        // Gray is computed from the pre-incremented pointer so it lands with the binary value.
        r_ptr_gray_r_o   <= r_ptr_p1_r ^ (r_ptr_p1_r >> 1);
      end
      r_count_r_o <= w_ptr_binary - r_ptr_binary_next;
      if (r_yumi_i & ~r_valid_o)
        r_underflow_r_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_async_ptr_gray_reader.sv
// Bench for bsg_async_ptr_gray_reader: directed scenarios plus random traffic against a
// pointer-arithmetic model, checked by a scoreboard monitor after every clock edge.
module tb_bsg_async_ptr_gray_reader;

  localparam int W = 7;
  localparam int SIZE = 1 << W;
  localparam int DEPTH = 1 << (W - 1);
  localparam int EW = 3 * W + 2;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] w_gray = '0;
  logic         yumi = 1'b0;
  logic         valid, empty, uf;
  logic [W-1:0] bin, gray, count;

  always #5 clk = ~clk;

  bsg_async_ptr_gray_reader #(.lg_size_p(W)) dut (
    .r_clk_i            (clk),
    .r_reset_i          (rst),
    .w_ptr_gray_rsync_i (w_gray),
    .r_yumi_i           (yumi),
    .r_valid_o          (valid),
    .r_empty_o          (empty),
    .r_ptr_binary_r_o   (bin),
    .r_ptr_gray_r_o     (gray),
    .r_count_r_o        (count),
    .r_underflow_r_o    (uf)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // reference model: absolute pointers modulo SIZE
  int m_rd = 0;
  int m_wr = 0;
  bit m_uf = 0;

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // driver: one clock of stimulus, expected post-edge outputs pushed to the queue
  task automatic issue(input int wr, input bit y);
    int occ;
    @(negedge clk);
    m_wr = wr % SIZE;
    w_gray = to_gray(m_wr);
    yumi = y;
    if (y && (m_wr != m_rd)) m_rd = (m_rd + 1) % SIZE;
    else if (y) m_uf = 1;
    occ = (m_wr - m_rd + SIZE) % SIZE;
    exp_q.push_back({(m_wr != m_rd), m_uf, W'(occ), to_gray(m_rd), W'(m_rd)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    yumi = 1'b0;
    w_gray = '0;
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    m_rd = 0; m_wr = 0; m_uf = 0;
    check("rst_bin", bin, 0);
    check("rst_gray", gray, 0);
    check("rst_count", count, 0);
    check("rst_uf", uf, 0);
    check("rst_valid", valid, 0);
    check("rst_empty", empty, 1);
    #1 rst = 1'b0;
  endtask

  // monitor: compares outputs shortly after each rising edge
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bin", bin, e[W-1:0]);
        check("gray", gray, e[2*W-1:W]);
        check("count", count, e[3*W-1:2*W]);
        check("underflow", uf, e[3*W]);
        check("valid", valid, e[3*W+1]);
        check("empty", empty, !e[3*W+1]);
      end
    end
  end

  initial begin
    int occ, inc;
    #2 rst = 1'b0;
    do_reset();

    // drain three entries from a write pointer of 3
    issue(3, 0);
    for (int i = 0; i < 4; i++) issue(3, 1);

    // underflow, sticky across legal pops
    do_reset();
    issue(0, 1);
    issue(2, 1);
    issue(2, 1);
    issue(2, 0);

    // full: 64 entries outstanding
    do_reset();
    issue(DEPTH, 0);

    // simultaneous write-pointer step and pop from read pointer 2
    do_reset();
    issue(5, 1);
    issue(5, 1);
    issue(6, 1);

    // wrap: walk read pointer to 126, then pop through 127 -> 0 -> 1
    do_reset();
    for (int i = 0; i < 126; i++) issue(i + 1, 1);
    issue(SIZE + 1, 0);
    for (int i = 0; i < 4; i++) issue(SIZE + 1, 1);

    // mid-stream reset, then random traffic keeping occupancy within depth
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      occ = (m_wr - m_rd + SIZE) % SIZE;
      inc = $urandom_range(0, 3);
      if (occ + inc > DEPTH) inc = DEPTH - occ;
      if ($urandom_range(0, 99) == 0) inc = DEPTH - occ;
      issue(m_wr + inc, ($urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 40)));
      if (i == 1500) do_reset();
    end

    @(negedge clk);
    yumi = 1'b0;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
